// File: rtl/traffic_engine.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_engine
//  Description : Lane traffic engine. Owns N_LANES cars that wrap across the
//                playfield, derives the base movement tick from the system
//                clock, shortens lane periods as the level rises, and answers
//                a registered occupancy lookup for the renderer and a
//                registered collision check for the player.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_engine #(
  parameter int N_LANES      = 9,
  parameter int GRID_W       = 20,
  parameter int X_W          = 5,
  parameter int Y_W          = 4,
  parameter int TICK_DIV     = 2500000,
  parameter logic [N_LANES*Y_W-1:0] LANE_Y =
    {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2},
  parameter logic [N_LANES*X_W-1:0] LANE_START =
    {5'd4, 5'd15, 5'd0, 5'd10, 5'd19, 5'd5, 5'd12, 5'd2, 5'd8},
  parameter logic [N_LANES*4-1:0] LANE_PERIOD =
    {4'd2, 4'd3, 4'd1, 4'd4, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3},
  parameter logic [N_LANES-1:0] LANE_DIR = 9'b101010101,
  parameter logic [N_LANES*2-1:0] LANE_LEN =
    {2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3},
  parameter int SPEEDUP_STEP = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_restart,
  input  logic [6:0]             i_level,
  input  logic [X_W-1:0]         i_query_x,
  input  logic [Y_W-1:0]         i_query_y,
  output logic                   o_query_hit,
  input  logic [X_W-1:0]         i_player_x,
  input  logic [Y_W-1:0]         i_player_y,
  output logic                   o_collision,
  output logic                   o_collision_pulse,
  output logic                   o_step,
  output logic [N_LANES*X_W-1:0] o_lane_x
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]   COL_LAST = X_W'(GRID_W - 1);

  // Column arithmetic with wrap-around at the playfield edges.
  function automatic logic [X_W-1:0] wrap_inc(input logic [X_W-1:0] x);
    return (x == COL_LAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [X_W-1:0] wrap_dec(input logic [X_W-1:0] x);
    return (x == '0) ? COL_LAST : x - 1'b1;
  endfunction

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [6:0]         level_red;
  logic [4:0]         red_sat;
  logic [N_LANES-1:0] query_lane_hit;
  logic [N_LANES-1:0] player_lane_hit;
  logic               query_occ;
  logic               player_occ;

  // A restart swallows the tick so it never races the reload.
  assign tick = i_enable && !i_restart && (div_cnt == DIV_LAST);

  // Level-based period reduction, saturated so the 5-bit subtract never wraps.
  assign level_red = i_level / 7'(SPEEDUP_STEP);
  assign red_sat   = (level_red > 7'd31) ? 5'd31 : level_red[4:0];

  // Base tick divider; o_step marks the wrap of the count.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt <= '0;
      o_step  <= 1'b0;
    end else if (i_restart) begin
      div_cnt <= '0;
      o_step  <= 1'b0;
    end else begin
      o_step <= tick;
      if (i_enable) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam logic [X_W-1:0] START   = LANE_START[i*X_W +: X_W];
    localparam logic [Y_W-1:0] ROW     = LANE_Y[i*Y_W +: Y_W];
    localparam logic           DIR     = LANE_DIR[i];
    localparam logic [1:0]     LEN_RAW = LANE_LEN[i*2 +: 2];
    localparam int             LEN     = (LEN_RAW == 2'd0) ? 1 : int'(LEN_RAW);
    localparam logic [4:0]     BASE    = {1'b0, LANE_PERIOD[i*4 +: 4]};

    logic [X_W-1:0] head;
    logic [X_W-1:0] head_next;
    logic [X_W-1:0] tail1;
    logic [X_W-1:0] tail2;
    logic [3:0]     cnt;
    logic [4:0]     peff;
    logic           move_due;

    assign peff      = (red_sat >= BASE) ? 5'd1 : BASE - red_sat;
    // ">=" rather than "==" so a period that shrinks mid-count still moves.
    assign move_due  = ({1'b0, cnt} >= (peff - 5'd1));
    assign head_next = DIR ? wrap_inc(head) : wrap_dec(head);
    // The tail trails opposite to the direction of travel.
    assign tail1     = DIR ? wrap_dec(head)  : wrap_inc(head);
    assign tail2     = DIR ? wrap_dec(tail1) : wrap_inc(tail1);

    assign query_lane_hit[i] = (i_query_y == ROW) &&
                               ((i_query_x == head) ||
                                ((LEN >= 2) && (i_query_x == tail1)) ||
                                ((LEN >= 3) && (i_query_x == tail2)));
    assign player_lane_hit[i] = (i_player_y == ROW) &&
                                ((i_player_x == head) ||
                                 ((LEN >= 2) && (i_player_x == tail1)) ||
                                 ((LEN >= 3) && (i_player_x == tail2)));

    assign o_lane_x[i*X_W +: X_W] = head;

    // Lane head and step counter; restart reloads before any movement.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        head <= START;
        cnt  <= '0;
      end else if (i_restart) begin
        head <= START;
        cnt  <= '0;
      end else if (tick) begin
        if (move_due) begin
          head <= head_next;
          cnt  <= '0;
        end else begin
          cnt  <= cnt + 4'd1;
        end
      end
    end
  end

  assign query_occ  = |query_lane_hit;
  assign player_occ = |player_lane_hit;

  // Registered lookup and collision; restart blanks collision for one cycle.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_query_hit       <= 1'b0;
      o_collision       <= 1'b0;
      o_collision_pulse <= 1'b0;
    end else begin
      o_query_hit <= query_occ;
      if (i_restart) begin
        o_collision       <= 1'b0;
        o_collision_pulse <= 1'b0;
      end else begin
        o_collision       <= player_occ;
        o_collision_pulse <= player_occ & ~o_collision;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_engine
//  Description : Self-checking bench for traffic_engine with a cycle-level
//                behavioural model and directed literal checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_engine;
  localparam int NL = 4;
  localparam int GW = 20;
  localparam int TD = 4;
  // Start columns packed lane3..lane0 = 10,0,19,5.
  localparam int START_PACKED = 5 + (19 << 5) + (0 << 10) + (10 << 15);

  int ST[NL]   = '{5, 19, 0, 10};
  int ROWY[NL] = '{2, 4, 7, 9};
  int PER[NL]  = '{2, 1, 1, 3};
  int DIRS[NL] = '{1, 1, 0, 0};
  int LENS[NL] = '{1, 3, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic [6:0]  level = 7'd0;
  logic [4:0]  qx = 5'd0;
  logic [3:0]  qy = 4'd0;
  logic [4:0]  px = 5'd0;
  logic [3:0]  py = 4'd15;
  logic        qhit, coll, pulse, step;
  logic [19:0] lane_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_engine #(
    .N_LANES(4), .GRID_W(20), .X_W(5), .Y_W(4), .TICK_DIV(TD),
    .LANE_Y({4'd9, 4'd7, 4'd4, 4'd2}),
    .LANE_START({5'd10, 5'd0, 5'd19, 5'd5}),
    .LANE_PERIOD({4'd3, 4'd1, 4'd1, 4'd2}),
    .LANE_DIR(4'b0011),
    .LANE_LEN({2'd1, 2'd2, 2'd3, 2'd1}),
    .SPEEDUP_STEP(10)
  ) dut (
    .i_Clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_restart(restart),
    .i_level(level), .i_query_x(qx), .i_query_y(qy), .o_query_hit(qhit),
    .i_player_x(px), .i_player_y(py), .o_collision(coll),
    .o_collision_pulse(pulse), .o_step(step), .o_lane_x(lane_x)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int l);
    return int'(lane_x[l*5 +: 5]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_head[NL];
  int m_acc[NL];
  int m_phase;
  bit m_step, m_qhit, m_coll, m_pulse;

  function automatic bit occ(input int x, input int y);
    for (int l = 0; l < NL; l++) begin
      int n = (LENS[l] == 0) ? 1 : LENS[l];
      if (y == ROWY[l]) begin
        for (int k = 0; k < n; k++) begin
          int col = DIRS[l] ? (m_head[l] - k + GW) % GW : (m_head[l] + k) % GW;
          if (col == x) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic int peff(input int l);
    int p = PER[l] - int'(level) / 10;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int m_lanes();
    int v = 0;
    for (int l = 0; l < NL; l++) v += m_head[l] << (5 * l);
    return v;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_head[l] = ST[l];
      m_acc[l]  = 0;
    end
    m_phase = 0;
    m_step = 0; m_qhit = 0; m_coll = 0; m_pulse = 0;
  endtask

  task automatic model_clock();
    bit nq, np;
    nq = occ(int'(qx), int'(qy));
    np = occ(int'(px), int'(py));
    m_qhit = nq;
    m_step = 0;
    if (restart) begin
      m_coll = 0; m_pulse = 0; m_phase = 0;
      for (int l = 0; l < NL; l++) begin
        m_head[l] = ST[l];
        m_acc[l]  = 0;
      end
    end else begin
      m_pulse = np && !m_coll;
      m_coll  = np;
      if (enable) begin
        if (m_phase == TD - 1) begin
          m_phase = 0;
          m_step  = 1;
          for (int l = 0; l < NL; l++) begin
            m_acc[l]++;
            if (m_acc[l] >= peff(l)) begin
              m_acc[l] = 0;
              m_head[l] = DIRS[l] ? (m_head[l] + 1) % GW : (m_head[l] + GW - 1) % GW;
            end
          end
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_lane_x", int'(lane_x), m_lanes());
      chk("m_step", int'(step), int'(m_step));
      chk("m_query_hit", int'(qhit), int'(m_qhit));
      chk("m_collision", int'(coll), int'(m_coll));
      chk("m_coll_pulse", int'(pulse), int'(m_pulse));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_lane_x", int'(lane_x), START_PACKED);
    chk("rst_step", int'(step), 0);
    chk("rst_qhit", int'(qhit), 0);
    chk("rst_coll", int'(coll), 0);
    chk("rst_pulse", int'(pulse), 0);

    rst_n = 1'b1; enable = 1'b1; px = 5'd6; py = 4'd2;
    for (int e = 1; e <= 44; e++) begin
      @(negedge clk);
      case (e)
        3:  chk("step_e3", int'(step), 0);
        4:  begin
              chk("step_e4", int'(step), 1);
              chk("l0_e4", lane(0), 5);
              chk("l1_wrap_e4", lane(1), 0);
              chk("l2_wrap_e4", lane(2), 19);
            end
        8:  begin
              chk("step_e8", int'(step), 1);
              chk("l0_e8", lane(0), 6);
              chk("l1_e8", lane(1), 1);
              chk("l2_e8", lane(2), 18);
              qx = 5'd1; qy = 4'd4;
            end
        9:  begin
              chk("coll_rise", int'(coll), 1);
              chk("pulse_rise", int'(pulse), 1);
              chk("q_head_1_4", int'(qhit), 1);
              qx = 5'd0;
            end
        10: begin
              chk("pulse_once", int'(pulse), 0);
              chk("coll_hold", int'(coll), 1);
              chk("q_tail_0_4", int'(qhit), 1);
              qx = 5'd19;
            end
        11: begin
              chk("q_tail_19_4", int'(qhit), 1);
              chk("l3_e11", lane(3), 10);
              qx = 5'd2;
            end
        12: begin
              chk("q_ahead_2_4", int'(qhit), 0);
              chk("step_e12", int'(step), 1);
              chk("l3_lvl0_e12", lane(3), 9);
              qx = 5'd1; qy = 4'd5; level = 7'd10;
            end
        13: chk("q_row5", int'(qhit), 0);
        16: begin
              chk("l0_e16", lane(0), 7);
              chk("l3_lvl10_e16", lane(3), 9);
            end
        17: chk("coll_fall", int'(coll), 0);
        20: begin chk("l3_lvl10_e20", lane(3), 8); level = 7'd25; end
        24: chk("l3_lvl25_e24", lane(3), 7);
        28: begin chk("l3_lvl25_e28", lane(3), 6); level = 7'd99; end
        32: chk("l3_lvl99_e32", lane(3), 5);
        36: begin
              chk("l3_lvl99_e36", lane(3), 4);
              chk("l0_e36", lane(0), 12);
            end
        37: px = 5'd12;
        38: begin
              chk("coll2_rise", int'(coll), 1);
              chk("pulse2_rise", int'(pulse), 1);
            end
        39: begin
              chk("pulse2_once", int'(pulse), 0);
              restart = 1'b1;
            end
        40: begin
              chk("rs_lane_x", int'(lane_x), START_PACKED);
              chk("rs_step", int'(step), 0);
              chk("rs_coll", int'(coll), 0);
              chk("rs_pulse", int'(pulse), 0);
              restart = 1'b0;
            end
        41: chk("rs_coll_after", int'(coll), 0);
        43: chk("rs_step_e43", int'(step), 0);
        44: begin
              chk("rs_step_e44", int'(step), 1);
              chk("rs_l0", lane(0), 6);
              chk("rs_l1", lane(1), 0);
              chk("rs_l2", lane(2), 19);
              chk("rs_l3", lane(3), 9);
              enable = 1'b0;
              qx = 5'd6; qy = 4'd2;
            end
        default: ;
      endcase
    end

    // Frozen traffic: positions hold, lookups stay live.
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) chk("frz_qhit", int'(qhit), 1);
      if (c == 1) chk("frz_step_c1", int'(step), 0);
    end
    chk("frz_lane_x", int'(lane_x), 6 + (0 << 5) + (19 << 10) + (9 << 15));
    chk("frz_step", int'(step), 0);

    // Asynchronous reset in mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lane_x", int'(lane_x), START_PACKED);
    chk("arst_step", int'(step), 0);
    chk("arst_qhit", int'(qhit), 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 3) chk("arst_l0_e3", lane(0), 5);
      if (e == 4) chk("arst_l0_e4", lane(0), 6);
      if (e == 4) chk("arst_step_e4", int'(step), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_engine.md
Name: traffic_engine

Overview:
- Parametrised lane-traffic engine that replaces the per-car instances and the car/player overlap logic in the top level.
- Owns N_LANES cars. Each lane has its own row, start column, direction, length and step period.
- Derives a movement tick from the system clock and speeds lanes up as the level rises.
- Provides a registered occupancy lookup for the VGA renderer and a registered collision output for the player/reset path.

Parameters:
N_LANES, 9, number of car lanes (1..16)
GRID_W, 20, playfield width in cells; columns 0..GRID_W-1
X_W, 5, column width in bits
Y_W, 4, row width in bits
TICK_DIV, 2500000, i_Clk cycles per base movement tick (10 Hz at 25 MHz)
LANE_Y, packed N_LANES*Y_W, row of each lane
LANE_START, packed N_LANES*X_W, head column after reset/restart
LANE_PERIOD, packed N_LANES*4, base ticks per one-cell step (1..15)
LANE_DIR, N_LANES bits, 1 = moves right (+x), 0 = moves left (-x)
LANE_LEN, packed N_LANES*2, car length in cells (1..3; 0 treated as 1)
SPEEDUP_STEP, 10, levels per 1-tick period reduction

Ports:
i_Clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_enable  in  1  1 = traffic moves; 0 = freeze all counters and positions
i_restart  in  1  synchronous pulse; reload all lanes to LANE_START and clear tick counters
i_level  in  7  current level, 0..99
i_query_x  in  X_W  renderer cell column
i_query_y  in  Y_W  renderer cell row
o_query_hit  out  1  queried cell is occupied by a car; 1-cycle latency
i_player_x  in  X_W  player column
i_player_y  in  Y_W  player row
o_collision  out  1  registered: player cell currently occupied
o_collision_pulse  out  1  one-cycle pulse on rising edge of o_collision
o_step  out  1  one-cycle pulse on every base tick
o_lane_x  out  N_LANES*X_W  head column of every lane, lane 0 in LSBs

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - o_lane_x = LANE_START.
  - Tick divider and lane counters = 0.
  - o_query_hit, o_collision, o_collision_pulse and o_step = 0.
- Base tick:
  - Divider counts 0..TICK_DIV-1 while i_enable=1; o_step pulses on the cycle the count wraps.
  - When i_enable=0 the divider holds and o_step=0.
- Effective period per lane: P_eff = max(1, LANE_PERIOD - (i_level / SPEEDUP_STEP)).
  - Computed in 5 bits with saturation; no underflow.
  - Example: period 3, level 25 gives P_eff = 1.
- Lane counter:
  - Advances on o_step.
  - When the counter is at or above P_eff-1: counter returns to 0 and the head moves one cell.
  - The "at or above" compare handles P_eff shrinking mid-count; no lost lane.
- Wrap-around:
  - Right-moving: GRID_W-1 goes to 0.
  - Left-moving: 0 goes to GRID_W-1.
  - Head is never outside 0..GRID_W-1.
- Occupied cells: row LANE_Y and columns head, head-d, head-2d (mod GRID_W), up to LANE_LEN cells.
  - d = +1 for right-moving lanes, -1 for left-moving; the tail trails behind the direction of travel.
  - The tail wraps across the screen edge.
- Occupancy function: OR over all lanes of (row match AND column in the occupied set).
  - Lanes sharing a row are legal.
- o_query_hit: occupancy(i_query_x, i_query_y), registered; valid exactly 1 cycle after the query inputs.
- o_collision: occupancy(i_player_x, i_player_y), registered each cycle.
  - o_collision_pulse = o_collision AND NOT its previous value.
  - A player standing in a car's path gets one pulse per entry.
- i_restart:
  - Takes priority over movement in the same cycle.
  - Positions reload to LANE_START and the divider and lane counters clear.
  - o_collision and o_collision_pulse are forced to 0 for that cycle, so there is no false pulse from stale positions.
- Reset mid-operation: all state returns to reset values immediately; first movement occurs TICK_DIV cycles after release.
- i_enable=0: lookups and collision remain live on frozen positions.

Test Plan:
- Reset: TICK_DIV=4, lane0 START=5, DIR=1, PERIOD=2, LEN=1; release reset, enable -> o_step at cycles 4, 8, 12; lane0 head 5 -> 6 at cycle 8, 7 at cycle 16.
- Wrap: lane DIR=1 starting at 19, PERIOD=1 -> head 19 -> 0 -> 1. Lane DIR=0 starting at 0 -> 19 -> 18.
- Length/tail wrap: LEN=3, DIR=1, head=1, row 4 -> o_query_hit=1 for columns 1, 0, 19 on row 4; 0 for column 2 and for row 5; each hit appears 1 cycle after the query.
- Speed-up: PERIOD=3. Level 0 -> steps every 3 ticks. Level 10 -> every 2. Level 25 -> every 1. Level 99 -> every 1 (saturated).
- Collision: player at (6,2), lane row 2 head moving 5 -> 6 -> o_collision rises the cycle after the move, o_collision_pulse high for exactly 1 cycle; player remains -> no further pulse.
- Restart/freeze:
  - i_restart asserted on the same cycle as a step -> heads equal LANE_START, no move, no collision pulse.
  - i_enable=0 for 100 cycles -> o_lane_x unchanged, o_step stays 0.
